// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline-stage register with valid/ready handshake, flush, optional
// two-entry skid buffer and saturating stall/flush performance counters.
module pipe_stage_reg #(
  parameter int DATA_W       = 160,
  parameter int SKID         = 1,
  parameter int ZERO_INVALID = 1,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (&cnt) ? cnt : cnt + CNT_W'(1);
  endfunction

  logic              vld_p1;
  logic [DATA_W-1:0] main_p1;
  logic [1:0]        occ_p1;
  logic              in_fire;
  logic              out_fire;

  assign in_fire  = in_valid & in_ready & ~flush;
  assign out_fire = vld_p1 & out_ready;

  generate
    if (SKID != 0) begin : g_skid
      typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;

      state_t            state;
      logic [DATA_W-1:0] skid_p1;
      logic              rdy_p1;

      // Stage boundary: main holds the head payload, skid the overflow entry.
      // in_ready comes straight from rdy_p1, so no combinational path from out_ready.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state   <= EMPTY;
          main_p1 <= '0;
          skid_p1 <= '0;
          vld_p1  <= 1'b0;
          occ_p1  <= 2'd0;
          rdy_p1  <= 1'b0;
        end else if (flush) begin
          state   <= EMPTY;
          main_p1 <= '0;
          skid_p1 <= '0;
          vld_p1  <= 1'b0;
          occ_p1  <= 2'd0;
          rdy_p1  <= 1'b1;
        end else begin
          case (state)
            EMPTY: begin
              rdy_p1 <= 1'b1;
              if (in_fire) begin
                state   <= BUSY;
                main_p1 <= in_data;
                vld_p1  <= 1'b1;
                occ_p1  <= 2'd1;
              end
            end
            BUSY: begin
              rdy_p1 <= 1'b1;
              if (in_fire && out_fire) begin
                main_p1 <= in_data;
              end else if (in_fire) begin
                state   <= FULL;
                skid_p1 <= in_data;
                occ_p1  <= 2'd2;
                rdy_p1  <= 1'b0;
              end else if (out_fire) begin
                state  <= EMPTY;
                vld_p1 <= 1'b0;
                occ_p1 <= 2'd0;
              end
            end
            FULL: begin
              if (out_fire) begin
                state   <= BUSY;
                main_p1 <= skid_p1;
                occ_p1  <= 2'd1;
                rdy_p1  <= 1'b1;
              end
            end
            default: begin
              state   <= EMPTY;
              main_p1 <= '0;
              skid_p1 <= '0;
              vld_p1  <= 1'b0;
              occ_p1  <= 2'd0;
              rdy_p1  <= 1'b1;
            end
          endcase
        end
      end

      assign in_ready = rdy_p1;
    end else begin : g_single
      logic rdy_en_p1;

      // Stage boundary: single entry; rdy_en_p1 holds in_ready low until the first
      // clock after reset release.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          main_p1   <= '0;
          vld_p1    <= 1'b0;
          rdy_en_p1 <= 1'b0;
        end else begin
          rdy_en_p1 <= 1'b1;
          if (flush) begin
            main_p1 <= '0;
            vld_p1  <= 1'b0;
          end else if (in_fire) begin
            main_p1 <= in_data;
            vld_p1  <= 1'b1;
          end else if (out_fire) begin
            vld_p1 <= 1'b0;
          end
        end
      end

      assign occ_p1   = {1'b0, vld_p1};
      assign in_ready = rdy_en_p1 & (~vld_p1 | out_ready);
    end
  endgenerate

  // Performance counters, saturating, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (vld_p1 && !out_ready) stall_cnt <= sat_inc(stall_cnt);
      if (flush)                flush_cnt <= sat_inc(flush_cnt);
    end
  end

  assign out_valid = vld_p1;
  assign occupancy = occ_p1;
  assign out_data  = (ZERO_INVALID != 0 && !vld_p1) ? '0 : main_p1;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomised and directed bench for pipe_stage_reg: four configurations share one
// stimulus stream, each checked against a bounded-FIFO reference model.
module tb_pipe_stage_reg;
  localparam int DW = 160;
  localparam int NI = 4;
  localparam int K_SKID [NI] = '{1, 0, 1, 1};
  localparam int K_ZI   [NI] = '{1, 1, 1, 0};
  localparam int K_MAX  [NI] = '{65535, 65535, 15, 65535};

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, out_ready;
  logic [DW-1:0] in_data;

  logic          ir_s1, ov_s1, ir_s0, ov_s0, ir_c4, ov_c4, ir_z0, ov_z0;
  logic [DW-1:0] od_s1, od_s0, od_c4, od_z0;
  logic [1:0]    oc_s1, oc_s0, oc_c4, oc_z0;
  logic [15:0]   sc_s1, fc_s1, sc_s0, fc_s0, sc_z0, fc_z0;
  logic [3:0]    sc_c4, fc_c4;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: a FIFO of at most two entries per configuration
  int            m_n    [NI];
  logic [DW-1:0] m_e0   [NI];
  logic [DW-1:0] m_e1   [NI];
  logic [DW-1:0] m_last [NI];
  int            m_st   [NI];
  int            m_fc   [NI];
  bit            m_go   [NI];

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DW), .SKID(1), .ZERO_INVALID(1), .CNT_W(16)) u_s1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir_s1),
    .in_data(in_data), .out_valid(ov_s1), .out_ready(out_ready), .out_data(od_s1),
    .occupancy(oc_s1), .stall_cnt(sc_s1), .flush_cnt(fc_s1));

  pipe_stage_reg #(.DATA_W(DW), .SKID(0), .ZERO_INVALID(1), .CNT_W(16)) u_s0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir_s0),
    .in_data(in_data), .out_valid(ov_s0), .out_ready(out_ready), .out_data(od_s0),
    .occupancy(oc_s0), .stall_cnt(sc_s0), .flush_cnt(fc_s0));

  pipe_stage_reg #(.DATA_W(DW), .SKID(1), .ZERO_INVALID(1), .CNT_W(4)) u_c4 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir_c4),
    .in_data(in_data), .out_valid(ov_c4), .out_ready(out_ready), .out_data(od_c4),
    .occupancy(oc_c4), .stall_cnt(sc_c4), .flush_cnt(fc_c4));

  pipe_stage_reg #(.DATA_W(DW), .SKID(1), .ZERO_INVALID(0), .CNT_W(16)) u_z0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir_z0),
    .in_data(in_data), .out_valid(ov_z0), .out_ready(out_ready), .out_data(od_z0),
    .occupancy(oc_z0), .stall_cnt(sc_z0), .flush_cnt(fc_z0));

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit m_ir(input int k);
    if (!m_go[k]) return 1'b0;
    if (K_SKID[k] != 0) return m_n[k] < 2;
    return (m_n[k] == 0) || out_ready;
  endfunction

  task automatic m_reset();
    for (int k = 0; k < NI; k++) begin
      m_n[k] = 0; m_e0[k] = '0; m_e1[k] = '0; m_last[k] = '0;
      m_st[k] = 0; m_fc[k] = 0; m_go[k] = 1'b0;
    end
  endtask

  task automatic m_step();
    for (int k = 0; k < NI; k++) begin
      bit inf, outf;
      inf  = in_valid && m_ir(k) && !flush;
      outf = (m_n[k] > 0) && out_ready;
      if (m_n[k] > 0 && !out_ready && m_st[k] < K_MAX[k]) m_st[k]++;
      if (flush && m_fc[k] < K_MAX[k]) m_fc[k]++;
      if (flush) begin
        m_n[k] = 0;
        m_last[k] = '0;
      end else begin
        if (outf) begin
          m_last[k] = m_e0[k];
          m_e0[k] = m_e1[k];
          m_n[k]--;
        end
        if (inf) begin
          if (m_n[k] == 0) m_e0[k] = in_data;
          else m_e1[k] = in_data;
          m_n[k]++;
        end
      end
      m_go[k] = 1'b1;
    end
  endtask

  task automatic check_inst(input int k, input logic ir, input logic ov, input logic [DW-1:0] od,
                            input logic [1:0] oc, input logic [31:0] sc, input logic [31:0] fc);
    logic [DW-1:0] exp_od;
    exp_od = (m_n[k] > 0) ? m_e0[k] : ((K_ZI[k] != 0) ? '0 : m_last[k]);
    chk($sformatf("i%0d_in_ready", k), DW'(ir), DW'(m_ir(k)));
    chk($sformatf("i%0d_out_valid", k), DW'(ov), DW'(m_n[k] > 0));
    chk($sformatf("i%0d_out_data", k), od, exp_od);
    chk($sformatf("i%0d_occupancy", k), DW'(oc), DW'(m_n[k]));
    chk($sformatf("i%0d_stall_cnt", k), DW'(sc), DW'(m_st[k]));
    chk($sformatf("i%0d_flush_cnt", k), DW'(fc), DW'(m_fc[k]));
  endtask

  task automatic check_all();
    check_inst(0, ir_s1, ov_s1, od_s1, oc_s1, 32'(sc_s1), 32'(fc_s1));
    check_inst(1, ir_s0, ov_s0, od_s0, oc_s0, 32'(sc_s0), 32'(fc_s0));
    check_inst(2, ir_c4, ov_c4, od_c4, oc_c4, 32'(sc_c4), 32'(fc_c4));
    check_inst(3, ir_z0, ov_z0, od_z0, oc_z0, 32'(sc_z0), 32'(fc_z0));
  endtask

  // Drive one cycle of inputs from the falling edge, check, then advance.
  task automatic cyc(input logic iv, input logic [DW-1:0] d, input logic ordy, input logic fl);
    in_valid = iv; in_data = d; out_ready = ordy; flush = fl;
    #1 check_all();
    @(posedge clk);
    if (!rst) m_step();
    @(negedge clk);
  endtask

  initial begin
    logic [DW-1:0] rd;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    m_reset();
    @(negedge clk);
    cyc(0, '0, 0, 0);
    cyc(1, 160'h5A, 1, 0);
    rst = 1'b0;
    cyc(0, '0, 1, 0);

    // streaming with out_ready held high
    cyc(1, 160'hA1, 1, 0);
    cyc(1, 160'hA2, 1, 0);
    cyc(1, 160'hA3, 1, 0);
    cyc(0, '0, 1, 0);
    cyc(0, '0, 1, 0);

    // backpressure fill then drain
    cyc(1, 160'h11, 0, 0);
    cyc(1, 160'h22, 0, 0);
    cyc(0, '0, 0, 0);
    cyc(0, '0, 0, 0);
    cyc(0, '0, 1, 0);
    cyc(0, '0, 1, 0);
    cyc(0, '0, 1, 0);

    // flush while FULL with a payload on the input
    cyc(1, 160'h55, 0, 0);
    cyc(1, 160'h66, 0, 0);
    cyc(1, 160'h33, 0, 1);
    #1;
    chk("flush_full_valid", DW'(ov_s1), DW'(0));
    chk("flush_full_data", od_s1, '0);
    chk("flush_full_ready", DW'(ir_s1), DW'(1));
    chk("flush_full_fcnt", DW'(fc_s1), DW'(1));
    cyc(0, '0, 1, 0);
    cyc(0, '0, 1, 0);

    // single-entry variant: combinational in_ready and bubble-free replace
    cyc(1, 160'h77, 0, 0);
    in_valid = 1'b0; out_ready = 1'b0;
    #1 chk("s0_ready_stalled", DW'(ir_s0), DW'(0));
    out_ready = 1'b1;
    #1 chk("s0_ready_released", DW'(ir_s0), DW'(1));
    cyc(1, 160'h44, 1, 0);
    #1 chk("s0_no_bubble", od_s0, 160'h44);
    cyc(0, '0, 1, 0);

    // counter saturation on the 4-bit instance
    cyc(1, 160'h99, 0, 0);
    for (int i = 0; i < 20; i++) cyc(0, '0, 0, 0);
    #1 chk("c4_stall_sat", DW'(sc_c4), DW'(15));

    // asynchronous reset while FULL
    cyc(1, 160'hBB, 0, 0);
    #2 rst = 1'b1;
    #1 m_reset();
    check_all();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc(0, '0, 1, 0);
    cyc(1, 160'hCC, 1, 0);
    cyc(0, '0, 1, 0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      rd = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      cyc(1'($urandom_range(0, 1)), rd, ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
